// File: rtl/rl_cell_alloc.sv
// rl_cell_alloc: packet-buffer cell allocator. Pops free cell IDs from an
// on-chip circular free list for each accepted metadata beat, and pushes
// cells back from the dispatch drop port (byte address) or the DMA
// completion port (cell ID). An in_use bitmap rejects double frees.
module rl_cell_alloc #(
  parameter int CELL_ID_WIDTH  = 8,
  parameter int CELL_SHIFT     = 11,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 16,
  parameter int APP_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LEN_WIDTH-1:0]      s_meta_len,
  input  logic [15:0]               s_meta_csum,
  input  logic [31:0]               s_meta_hash,
  input  logic [APP_ID_WIDTH-1:0]   s_meta_app_id,
  input  logic                      s_meta_valid,
  output logic                      s_meta_ready,
  output logic [CELL_ID_WIDTH-1:0]  m_desc_cell_id,
  output logic [LEN_WIDTH-1:0]      m_desc_len,
  output logic [15:0]               m_desc_csum,
  output logic [31:0]               m_desc_hash,
  output logic [APP_ID_WIDTH-1:0]   m_desc_app_id,
  output logic                      m_desc_valid,
  input  logic                      m_desc_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] s_drop_free_addr,
  input  logic                      s_drop_free_valid,
  output logic                      s_drop_free_ready,
  input  logic [CELL_ID_WIDTH-1:0]  s_dma_free_cell,
  input  logic                      s_dma_free_valid,
  output logic                      s_dma_free_ready,
  output logic [CELL_ID_WIDTH:0]    free_count,
  output logic [15:0]               double_free_cnt,
  output logic                      init_done
);

  localparam int CELL_COUNT = 2 ** CELL_ID_WIDTH;
  localparam int CNT_W      = CELL_ID_WIDTH + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   state, state_nxt;
  logic [CELL_ID_WIDTH-1:0] list [CELL_COUNT];
  logic [CELL_ID_WIDTH-1:0] head, tail, init_ptr;
  logic [CNT_W-1:0]         count;
  logic [CELL_COUNT-1:0]    in_use;

  logic                     run, alloc, init_wr;
  logic                     drop_acc, dma_acc, free_acc, free_ok, free_dup;
  logic [CELL_ID_WIDTH-1:0] drop_cell, free_cell, alloc_cell;
  logic                     list_we;
  logic [CELL_ID_WIDTH-1:0] list_wdata;
  logic [CNT_W-1:0]         count_nxt;

  assign drop_cell  = CELL_ID_WIDTH'(s_drop_free_addr >> CELL_SHIFT);
  assign alloc_cell = list[head];
  assign free_count = count;

  // Handshakes, free arbitration (drop port wins) and list write selection
  always_comb begin
    run               = (state == ST_RUN);
    s_meta_ready      = run && (count != '0) && (!m_desc_valid || m_desc_ready);
    s_drop_free_ready = run;
    s_dma_free_ready  = run && !s_drop_free_valid;
    alloc             = s_meta_valid && s_meta_ready;
    drop_acc          = s_drop_free_valid && s_drop_free_ready;
    dma_acc           = s_dma_free_valid && s_dma_free_ready;
    free_acc          = drop_acc || dma_acc;
    free_cell         = drop_acc ? drop_cell : s_dma_free_cell;
    free_ok           = free_acc && in_use[free_cell];
    free_dup          = free_acc && !in_use[free_cell];
    init_wr           = (state == ST_INIT);
    list_we           = init_wr || free_ok;
    list_wdata        = init_wr ? init_ptr : free_cell;
    count_nxt         = count;
    if (init_wr)
      count_nxt = count + CNT_W'(1);
    else if (free_ok && !alloc)
      count_nxt = count + CNT_W'(1);
    else if (alloc && !free_ok)
      count_nxt = count - CNT_W'(1);
  end

  // Next-state: INIT walks every cell once, then stays in RUN until reset
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && (&init_ptr))
      state_nxt = ST_RUN;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Free-list storage: no reset, contents are rebuilt by INIT
  always_ff @(posedge clk) begin
    if (list_we) list[tail] <= list_wdata;
  end

  // Pointers, occupancy count, init sequencing and double-free counter
  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      init_ptr        <= '0;
      count           <= '0;
      init_done       <= 1'b0;
      double_free_cnt <= '0;
    end else begin
      count <= count_nxt;
      if (list_we) tail <= tail + CELL_ID_WIDTH'(1);
      if (alloc)   head <= head + CELL_ID_WIDTH'(1);
      if (init_wr) init_ptr <= init_ptr + CELL_ID_WIDTH'(1);
      if (init_wr && (&init_ptr)) init_done <= 1'b1;
      if (free_dup && double_free_cnt != 16'hFFFF)
        double_free_cnt <= double_free_cnt + 16'd1;
    end
  end

  // Ownership bitmap; an alloc and a valid free never target the same cell
  always_ff @(posedge clk) begin
    if (rst) begin
      in_use <= '0;
    end else begin
      if (alloc)   in_use[alloc_cell] <= 1'b1;
      if (free_ok) in_use[free_cell]  <= 1'b0;
    end
  end

  // Descriptor output register: load on accept, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      m_desc_valid   <= 1'b0;
      m_desc_cell_id <= '0;
      m_desc_len     <= '0;
      m_desc_csum    <= '0;
      m_desc_hash    <= '0;
      m_desc_app_id  <= '0;
    end else if (alloc) begin
      m_desc_valid   <= 1'b1;
      m_desc_cell_id <= alloc_cell;
      m_desc_len     <= s_meta_len;
      m_desc_csum    <= s_meta_csum;
      m_desc_hash    <= s_meta_hash;
      m_desc_app_id  <= s_meta_app_id;
    end else if (m_desc_ready) begin
      m_desc_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rl_cell_alloc.sv
// Directed bench for rl_cell_alloc: init, alloc, backpressure, empty list,
// free arbitration, double free and mid-traffic reset.
module tb_rl_cell_alloc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_meta_len;
  logic [15:0] s_meta_csum;
  logic [31:0] s_meta_hash;
  logic [3:0]  s_meta_app_id;
  logic        s_meta_valid;
  logic        s_meta_ready;
  logic [7:0]  m_desc_cell_id;
  logic [15:0] m_desc_len;
  logic [15:0] m_desc_csum;
  logic [31:0] m_desc_hash;
  logic [3:0]  m_desc_app_id;
  logic        m_desc_valid;
  logic        m_desc_ready;
  logic [15:0] s_drop_free_addr;
  logic        s_drop_free_valid;
  logic        s_drop_free_ready;
  logic [7:0]  s_dma_free_cell;
  logic        s_dma_free_valid;
  logic        s_dma_free_ready;
  logic [8:0]  free_count;
  logic [15:0] double_free_cnt;
  logic        init_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rl_cell_alloc dut (
    .clk(clk), .rst(rst),
    .s_meta_len(s_meta_len), .s_meta_csum(s_meta_csum), .s_meta_hash(s_meta_hash),
    .s_meta_app_id(s_meta_app_id), .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready),
    .m_desc_cell_id(m_desc_cell_id), .m_desc_len(m_desc_len), .m_desc_csum(m_desc_csum),
    .m_desc_hash(m_desc_hash), .m_desc_app_id(m_desc_app_id), .m_desc_valid(m_desc_valid),
    .m_desc_ready(m_desc_ready),
    .s_drop_free_addr(s_drop_free_addr), .s_drop_free_valid(s_drop_free_valid),
    .s_drop_free_ready(s_drop_free_ready),
    .s_dma_free_cell(s_dma_free_cell), .s_dma_free_valid(s_dma_free_valid),
    .s_dma_free_ready(s_dma_free_ready),
    .free_count(free_count), .double_free_cnt(double_free_cnt), .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic meta(input logic v, input logic [15:0] len, input logic [3:0] app);
    s_meta_valid  = v;
    s_meta_len    = len;
    s_meta_csum   = 16'hA000 | len;
    s_meta_hash   = 32'hDEAD0000 | 32'(len);
    s_meta_app_id = app;
  endtask

  initial begin
    rst = 1'b1;
    meta(1'b0, 16'd0, 4'd0);
    m_desc_ready = 1'b0;
    s_drop_free_addr = '0; s_drop_free_valid = 1'b0;
    s_dma_free_cell = '0;  s_dma_free_valid = 1'b0;

    // 1: reset state, then 256-cycle init
    tick(); tick();
    chk("rst_free_count", 32'(free_count), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_desc_valid", 32'(m_desc_valid), 0);
    chk("rst_drop_ready", 32'(s_drop_free_ready), 0);
    chk("rst_dfc", 32'(double_free_cnt), 0);
    rst = 1'b0;
    repeat (255) tick();
    chk("init_cnt_255", 32'(free_count), 255);
    chk("init_done_early", 32'(init_done), 0);
    chk("init_drop_ready_low", 32'(s_drop_free_ready), 0);
    tick();
    chk("init_done", 32'(init_done), 1);
    chk("init_cnt_256", 32'(free_count), 256);
    chk("run_drop_ready", 32'(s_drop_free_ready), 1);

    // 2: three back-to-back allocs
    m_desc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      meta(1'b1, 16'(100 + i), 4'(i + 1));
      #1 chk("alloc_meta_ready", 32'(s_meta_ready), 1);
      tick();
      chk("alloc_valid", 32'(m_desc_valid), 1);
      chk("alloc_cell", 32'(m_desc_cell_id), 32'(i));
      chk("alloc_len", 32'(m_desc_len), 32'(100 + i));
      chk("alloc_csum", 32'(m_desc_csum), 32'(16'hA000 | 16'(100 + i)));
      chk("alloc_hash", m_desc_hash, 32'hDEAD0000 | 32'(100 + i));
      chk("alloc_app", 32'(m_desc_app_id), 32'(i + 1));
    end
    meta(1'b0, 16'd0, 4'd0);
    tick();
    chk("alloc_valid_drop", 32'(m_desc_valid), 0);
    chk("alloc_cnt_253", 32'(free_count), 253);

    // 3: backpressure holds first descriptor, second waits
    m_desc_ready = 1'b0;
    meta(1'b1, 16'd200, 4'd7);
    tick();
    chk("bp_cell_a", 32'(m_desc_cell_id), 3);
    meta(1'b1, 16'd201, 4'd8);
    #1 chk("bp_meta_ready_low", 32'(s_meta_ready), 0);
    tick();
    chk("bp_held_valid", 32'(m_desc_valid), 1);
    chk("bp_held_cell", 32'(m_desc_cell_id), 3);
    chk("bp_held_len", 32'(m_desc_len), 200);
    m_desc_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(s_meta_ready), 1);
    tick();
    chk("bp_cell_b", 32'(m_desc_cell_id), 4);
    chk("bp_len_b", 32'(m_desc_len), 201);
    meta(1'b0, 16'd0, 4'd0);
    tick();
    chk("bp_cnt", 32'(free_count), 251);

    // 4: drain the list, then a DMA free feeds the next alloc
    meta(1'b1, 16'd300, 4'd2);
    repeat (251) tick();
    chk("drain_last_cell", 32'(m_desc_cell_id), 255);
    chk("drain_cnt_0", 32'(free_count), 0);
    chk("drain_meta_ready", 32'(s_meta_ready), 0);
    s_dma_free_cell = 8'd5; s_dma_free_valid = 1'b1;
    #1 chk("empty_dma_ready", 32'(s_dma_free_ready), 1);
    tick();
    s_dma_free_valid = 1'b0;
    chk("empty_free_cnt_1", 32'(free_count), 1);
    #1 chk("empty_meta_ready", 32'(s_meta_ready), 1);
    tick();
    chk("realloc_cell_5", 32'(m_desc_cell_id), 5);
    chk("realloc_cnt_0", 32'(free_count), 0);
    meta(1'b0, 16'd0, 4'd0);
    tick();

    // 5: simultaneous drop (cell 3) and DMA (cell 7) frees
    s_drop_free_addr = 16'h1800; s_drop_free_valid = 1'b1;
    s_dma_free_cell = 8'd7;      s_dma_free_valid = 1'b1;
    #1 chk("arb_drop_ready", 32'(s_drop_free_ready), 1);
    chk("arb_dma_blocked", 32'(s_dma_free_ready), 0);
    tick();
    s_drop_free_valid = 1'b0;
    chk("arb_cnt_1", 32'(free_count), 1);
    #1 chk("arb_dma_ready", 32'(s_dma_free_ready), 1);
    tick();
    s_dma_free_valid = 1'b0;
    chk("arb_cnt_2", 32'(free_count), 2);

    // 6: double free of cell 3 is rejected
    s_drop_free_addr = 16'h1800; s_drop_free_valid = 1'b1;
    tick();
    s_drop_free_valid = 1'b0;
    chk("dbl_cnt", 32'(double_free_cnt), 1);
    chk("dbl_free_count", 32'(free_count), 2);
    // list order after the frees is 3 then 7
    meta(1'b1, 16'd400, 4'd3);
    tick();
    chk("order_cell_3", 32'(m_desc_cell_id), 3);
    meta(1'b1, 16'd401, 4'd3);
    tick();
    chk("order_cell_7", 32'(m_desc_cell_id), 7);
    chk("order_cnt_0", 32'(free_count), 0);

    // mid-traffic reset wipes everything and restarts init
    rst = 1'b1;
    tick();
    chk("mrst_valid", 32'(m_desc_valid), 0);
    chk("mrst_cnt", 32'(free_count), 0);
    chk("mrst_init_done", 32'(init_done), 0);
    chk("mrst_dfc", 32'(double_free_cnt), 0);
    chk("mrst_meta_ready", 32'(s_meta_ready), 0);
    rst = 1'b0;
    repeat (256) tick();
    chk("mrst_reinit_done", 32'(init_done), 1);
    chk("mrst_reinit_cnt", 32'(free_count), 256);
    tick();
    chk("mrst_first_cell", 32'(m_desc_cell_id), 0);
    chk("mrst_first_len", 32'(m_desc_len), 401);
    meta(1'b0, 16'd0, 4'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
